aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- sequencing controller for an iterative AES-128-style
// encryption datapath. It walks the datapath through the initial key load,
// then SUBBYTES / SHIFTROWS / MIXCOLUMNS / ADDROUNDKEY for each round
// (the final round skips MIXCOLUMNS), and presents the finished ciphertext
// through a valid/ready handshake.
//
// Parameters
//   N_ROUNDS   number of cipher rounds (1..15)
//   STAGE_LAT  cycles each registered transform stage needs (1..7)
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset (overrides every input)
//   start_valid  requester offers a new block
//   start_ready  controller idle and able to accept a block
//   abort        cancel the operation in progress (ignored while idle)
//   key_valid    round key for key_round is available this cycle
//   key_req      round key requested (LOAD and ARK only)
//   key_round    index of the requested round key
//   load_en      datapath loads input block XOR key 0
//   stage_sel    active transform: 0 SUB, 1 SHIFT, 2 MIX, 3 ARK
//   stage_en     one-cycle launch strobe for the stage in stage_sel
//   round        current round number (0 during load)
//   busy         controller not idle
//   done_valid   datapath state holds the finished ciphertext
//   done_ready   consumer accepts the result
module aes_round_ctrl #(
  parameter int unsigned N_ROUNDS  = 10,
  parameter int unsigned STAGE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  input  logic       key_valid,
  output logic       key_req,
  output logic [3:0] key_round,
  output logic       load_en,
  output logic [1:0] stage_sel,
  output logic       stage_en,
  output logic [3:0] round,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_ARK,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(STAGE_LAT - 1);
  localparam logic [3:0] RND_LAST = 4'(N_ROUNDS);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [3:0] rnd, rnd_nx;

  logic stage_first;
  logic stage_last;
  logic final_round;

  assign stage_first = (cnt == 3'd0);
  assign stage_last  = (cnt == LAT_LAST);
  assign final_round = (rnd == RND_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rnd   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rnd   <= rnd_nx;
    end
  end

  // Next-state logic. Abort takes priority over every handshake so that a
  // key or result offered in the abort cycle is left unconsumed.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rnd_nx   = rnd;
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      rnd_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            state_nx = S_LOAD;
            cnt_nx   = '0;
            rnd_nx   = '0;
          end
        end
        S_LOAD: begin
          if (key_valid) begin
            state_nx = S_SUB;
            cnt_nx   = '0;
            rnd_nx   = 4'd1;
          end
        end
        S_SUB: begin
          if (stage_last) begin
            state_nx = S_SHIFT;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
        S_SHIFT: begin
          if (stage_last) begin
            // Final round has no MIXCOLUMNS step.
            state_nx = final_round ? S_ARK : S_MIX;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
        S_MIX: begin
          if (stage_last) begin
            state_nx = S_ARK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
        S_ARK: begin
          if (key_valid) begin
            cnt_nx = '0;
            if (final_round) begin
              state_nx = S_DONE;
            end else begin
              state_nx = S_SUB;
              rnd_nx   = rnd + 4'd1;
            end
          end
        end
        S_DONE: begin
          if (done_ready) begin
            state_nx = S_IDLE;
            rnd_nx   = '0;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          rnd_nx   = '0;
        end
      endcase
    end
  end

  // Output decode. Strobes and done_valid are masked by abort so that a
  // cancelled cycle never launches a stage or presents a result.
  always_comb begin
    start_ready = 1'b0;
    key_req     = 1'b0;
    key_round   = '0;
    load_en     = 1'b0;
    stage_sel   = 2'd0;
    stage_en    = 1'b0;
    busy        = 1'b1;
    done_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_LOAD: begin
        key_req = 1'b1;
        load_en = key_valid & ~abort;
      end
      S_SUB: begin
        stage_sel = 2'd0;
        stage_en  = stage_first & ~abort;
      end
      S_SHIFT: begin
        stage_sel = 2'd1;
        stage_en  = stage_first & ~abort;
      end
      S_MIX: begin
        stage_sel = 2'd2;
        stage_en  = stage_first & ~abort;
      end
      S_ARK: begin
        stage_sel = 2'd3;
        key_req   = 1'b1;
        key_round = rnd;
        stage_en  = key_valid & ~abort;
      end
      S_DONE: begin
        done_valid = ~abort;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign round = rnd;

  // Internal sanity properties
  a_round_bound: assert property (@(posedge clk) rnd <= RND_LAST);
  a_cnt_bound:   assert property (@(posedge clk) cnt <= LAT_LAST);

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_valid, abort, key_valid, done_ready;

  logic       sr [3];
  logic       kq [3];
  logic [3:0] kr [3];
  logic       le [3];
  logic [1:0] ss [3];
  logic       se [3];
  logic [3:0] rd [3];
  logic       bz [3];
  logic       dv [3];

  aes_round_ctrl #(.N_ROUNDS(10), .STAGE_LAT(1)) u_d0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[0]),
    .abort(abort), .key_valid(key_valid), .key_req(kq[0]), .key_round(kr[0]),
    .load_en(le[0]), .stage_sel(ss[0]), .stage_en(se[0]), .round(rd[0]),
    .busy(bz[0]), .done_valid(dv[0]), .done_ready(done_ready));

  aes_round_ctrl #(.N_ROUNDS(10), .STAGE_LAT(3)) u_d1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[1]),
    .abort(abort), .key_valid(key_valid), .key_req(kq[1]), .key_round(kr[1]),
    .load_en(le[1]), .stage_sel(ss[1]), .stage_en(se[1]), .round(rd[1]),
    .busy(bz[1]), .done_valid(dv[1]), .done_ready(done_ready));

  aes_round_ctrl #(.N_ROUNDS(1), .STAGE_LAT(2)) u_d2 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[2]),
    .abort(abort), .key_valid(key_valid), .key_req(kq[2]), .key_round(kr[2]),
    .load_en(le[2]), .stage_sel(ss[2]), .stage_en(se[2]), .round(rd[2]),
    .busy(bz[2]), .done_valid(dv[2]), .done_ready(done_ready));

  // Step kinds of the reference schedule
  localparam int K_SUB = 0, K_SHIFT = 1, K_MIX = 2, K_ARK = 3,
                 K_LOAD = 4, K_DONE = 5, K_IDLE = 6;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int pos [3];
  int done_at [3];

  function automatic int cfg_lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic int cfg_nr(input int i);
    return (i == 2) ? 1 : 10;
  endfunction

  // Reference model: an encryption is a fixed schedule of positions.
  // Position 0 is idle, 1 is the key-0 load, then every round is a run of
  // L SUB, L SHIFT, (L MIX unless final), one ARK; DONE follows the last ARK.
  function automatic void decode(input int p_in, input int L, input int N,
                                 output int kind, output int rnd, output bit first);
    int p, o, len;
    kind = K_IDLE; rnd = 0; first = 1'b0;
    if (p_in == 1) begin
      kind = K_LOAD;
    end else if (p_in > 1) begin
      p = p_in - 2;
      len = 3 * L + 1;
      if (p < (N - 1) * len) begin
        rnd = p / len + 1;
        o = p % len;
      end else begin
        rnd = N;
        o = p - (N - 1) * len;
      end
      if (o < L) begin
        kind = K_SUB; first = (o == 0);
      end else if (o < 2 * L) begin
        kind = K_SHIFT; first = (o == L);
      end else if (rnd < N && o < 3 * L) begin
        kind = K_MIX; first = (o == 2 * L);
      end else if ((rnd < N) ? (o == 3 * L) : (o == 2 * L)) begin
        kind = K_ARK;
      end else begin
        kind = K_DONE;
      end
    end
  endfunction

  function automatic logic [15:0] expect_out(input int p, input int L, input int N,
                                             input logic kv, input logic ab);
    int kind, rnd;
    bit first;
    logic sr_e, kq_e, le_e, se_e, bz_e, dv_e;
    logic [3:0] kr_e, rd_e;
    logic [1:0] ss_e;
    decode(p, L, N, kind, rnd, first);
    sr_e = 1'b0; kq_e = 1'b0; le_e = 1'b0; se_e = 1'b0; dv_e = 1'b0;
    kr_e = '0; ss_e = '0;
    bz_e = (kind != K_IDLE);
    rd_e = 4'(rnd);
    case (kind)
      K_IDLE: sr_e = 1'b1;
      K_LOAD: begin kq_e = 1'b1; le_e = kv & ~ab; end
      K_SUB, K_SHIFT, K_MIX: begin ss_e = 2'(kind); se_e = first & ~ab; end
      K_ARK: begin ss_e = 2'd3; kq_e = 1'b1; kr_e = 4'(rnd); se_e = kv & ~ab; end
      K_DONE: dv_e = ~ab;
      default: ;
    endcase
    return {sr_e, kq_e, kr_e, le_e, ss_e, se_e, rd_e, bz_e, dv_e};
  endfunction

  function automatic int next_pos(input int p, input int L, input int N,
                                  input logic r, input logic sv, input logic ab,
                                  input logic kv, input logic dr);
    int kind, rnd;
    bit first;
    decode(p, L, N, kind, rnd, first);
    if (r) return 0;
    if (kind == K_IDLE) return sv ? 1 : 0;
    if (ab) return 0;
    if (kind == K_LOAD || kind == K_ARK) return kv ? p + 1 : p;
    if (kind == K_DONE) return dr ? 0 : p;
    return p + 1;
  endfunction

  function automatic logic [15:0] act_vec(input int i);
    return {sr[i], kq[i], kr[i], le[i], ss[i], se[i], rd[i], bz[i], dv[i]};
  endfunction

  function automatic bit all_idle();
    return !(bz[0] | bz[1] | bz[2]);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    ncmp++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic compare_all();
    logic [15:0] e, a;
    for (int i = 0; i < 3; i++) begin
      e = expect_out(pos[i], cfg_lat(i), cfg_nr(i), key_valid, abort);
      a = act_vec(i);
      ncmp++;
      if (a !== e) begin
        nfail++;
        $display("FAIL outputs_dut%0d cyc=%0d actual=%h required=%h", i, cyc, a, e);
      end
      if (dv[i] === 1'b1 && done_at[i] < 0) done_at[i] = cyc;
    end
  endtask

  // One clock cycle: check outputs on the falling edge, advance the model
  // on the rising edge, then hand control back just after it.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      pos[i] = next_pos(pos[i], cfg_lat(i), cfg_nr(i), rst, start_valid,
                        abort, key_valid, done_ready);
    cyc++;
    #1;
  endtask

  task automatic scenario_checks(input int mode, input int k);
    case (mode)
      0: begin
        if (k == 1)  chk("load_en_cycle1", int'(le[0]), 1);
        if (k == 39) chk("r10_shift", int'({ss[0], rd[0]}), int'({2'd1, 4'd10}));
        if (k == 40) chk("r10_ark_no_mix", int'({ss[0], rd[0]}), int'({2'd3, 4'd10}));
      end
      1: if (k == 15) chk("stall_ark_r3", int'({kq[0], kr[0], se[0]}), int'({1'b1, 4'd3, 1'b0}));
      2: begin
        if (k == 20) chk("abort_in_mix_r5", int'({ss[0], rd[0]}), int'({2'd2, 4'd5}));
        if (k == 21) chk("after_abort", int'({bz[0], sr[0], rd[0]}), int'({1'b0, 1'b1, 4'd0}));
      end
      3: begin
        if (k >= 41 && k <= 50) chk("done_hold", int'({dv[0], sr[0]}), 2);
        if (k == 52) chk("done_release", int'({bz[0], sr[0], dv[0]}), 2);
      end
      4: begin
        if (k == 27) chk("rst_in_shift_r7", int'({ss[0], rd[0]}), int'({2'd1, 4'd7}));
        if (k == 28) begin
          chk("post_rst_d0", int'(act_vec(0)), 32'h8000);
          chk("post_rst_d1", int'(act_vec(1)), 32'h8000);
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_scenario(input int mode, output int t0);
    bit finished;
    finished = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) done_at[i] = -1;
    for (int k = 0; k < 400; k++) begin
      start_valid = (k == 0) || (mode == 3 && k >= 44 && k <= 46);
      key_valid   = !(mode == 1 && k >= 13 && k <= 17);
      abort       = (mode == 2 && k == 20) || (mode == 4 && k == 27);
      rst         = (mode == 4 && k == 27);
      done_ready  = !(mode == 3 && k < 51);
      #1;
      scenario_checks(mode, k);
      if (k > 0 && all_idle() && (mode != 4 || k >= 150)) begin
        finished = 1'b1;
        break;
      end
      step();
    end
    chk($sformatf("scenario%0d_terminates", mode), int'(finished), 1);
  endtask

  initial begin
    int t0, kind, rnd, dpos;
    bit first;

    // Pin the model's own schedule against hand-computed latencies.
    for (int i = 0; i < 3; i++) begin
      dpos = -1;
      for (int p = 1; p < 200 && dpos < 0; p++) begin
        decode(p, cfg_lat(i), cfg_nr(i), kind, rnd, first);
        if (kind == K_DONE) dpos = p;
      end
      chk($sformatf("model_done_pos%0d", i), dpos, (i == 0) ? 41 : (i == 1) ? 99 : 7);
    end

    rst = 1'b1; start_valid = 1'b0; abort = 1'b1; key_valid = 1'b1; done_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0;
      done_at[i] = -1;
      chk($sformatf("reset_state%0d", i), int'(act_vec(i)), 32'h8000);
    end

    run_scenario(0, t0);
    chk("latency_L1", done_at[0] - t0, 41);
    chk("latency_L3", done_at[1] - t0, 99);
    chk("latency_N1_L2", done_at[2] - t0, 7);

    run_scenario(1, t0);
    chk("latency_stalled", done_at[0] - t0, 46);

    run_scenario(2, t0);
    chk("abort_no_done", done_at[0], -1);
    run_scenario(0, t0);
    chk("latency_after_abort", done_at[0] - t0, 41);

    run_scenario(3, t0);
    chk("latency_hold", done_at[0] - t0, 41);

    run_scenario(4, t0);
    chk("reset_no_done_d0", done_at[0], -1);
    chk("reset_no_done_d1", done_at[1], -1);

    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      start_valid = 1'($urandom_range(0, 1));
      key_valid   = ($urandom_range(0, 3) != 0);
      done_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
